// File: rtl/cont_sequencer_if.sv
// rtl/cont_sequencer_if.sv - command and monitor signal bundle for cont_sequencer
interface cont_sequencer_if #(
  parameter int WIDTH  = 4,
  parameter int RWIDTH = 4
);
  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  lim1;
  logic [WIDTH-1:0]  lim2;
  logic [RWIDTH-1:0] rounds;
  logic [WIDTH-1:0]  sa1;
  logic [WIDTH-1:0]  sa2;
  logic [RWIDTH-1:0] round;
  logic [1:0]        phase;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, lim1, lim2, rounds,
    input  sa1, sa2, round, phase, busy, done
  );

  modport slave (
    input  start, abort, lim1, lim2, rounds,
    output sa1, sa2, round, phase, busy, done
  );
endinterface

// File: rtl/cont_sequencer.sv
// rtl/cont_sequencer.sv - runs two up-counters in alternation for a programmed number of rounds
module cont_sequencer #(
  parameter int WIDTH  = 4,
  parameter int RWIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  cont_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN1 = 2'd1,
    RUN2 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sa1_q, sa1_d;
  logic [WIDTH-1:0]  sa2_q, sa2_d;
  logic [RWIDTH-1:0] round_q, round_d;
  logic [WIDTH-1:0]  lim1_q, lim1_d;
  logic [WIDTH-1:0]  lim2_q, lim2_d;
  logic [RWIDTH-1:0] rounds_q, rounds_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sa1_q    <= '0;
      sa2_q    <= '0;
      round_q  <= '0;
      lim1_q   <= '0;
      lim2_q   <= '0;
      rounds_q <= '0;
    end else begin
      state_q  <= state_d;
      sa1_q    <= sa1_d;
      sa2_q    <= sa2_d;
      round_q  <= round_d;
      lim1_q   <= lim1_d;
      lim2_q   <= lim2_d;
      rounds_q <= rounds_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa1_d    = sa1_q;
    sa2_d    = sa2_q;
    round_d  = round_q;
    lim1_d   = lim1_q;
    lim2_d   = lim2_q;
    rounds_d = rounds_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          lim1_d   = bus.lim1;
          lim2_d   = bus.lim2;
          rounds_d = bus.rounds;
          sa1_d    = '0;
          sa2_d    = '0;
          round_d  = '0;
          state_d  = (bus.rounds == '0) ? DONE : RUN1;
        end
      end
      RUN1: begin
        // abort outranks every counting transition
        if (bus.abort) begin
          state_d = IDLE;
          sa1_d   = '0;
          sa2_d   = '0;
          round_d = '0;
        end else if (sa1_q == lim1_q) begin
          state_d = RUN2;
        end else begin
          sa1_d = sa1_q + WIDTH'(1);
        end
      end
      RUN2: begin
        if (bus.abort) begin
          state_d = IDLE;
          sa1_d   = '0;
          sa2_d   = '0;
          round_d = '0;
        end else if (sa2_q != lim2_q) begin
          sa2_d = sa2_q + WIDTH'(1);
        end else if ((round_q + RWIDTH'(1)) == rounds_q) begin
          state_d = DONE;
        end else begin
          round_d = round_q + RWIDTH'(1);
          sa1_d   = '0;
          sa2_d   = '0;
          state_d = RUN1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.sa1   = sa1_q;
  assign bus.sa2   = sa2_q;
  assign bus.round = round_q;
  assign bus.phase = state_q;
  assign bus.busy  = (state_q == RUN1) || (state_q == RUN2);
  assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_cont_sequencer.sv
// tb/tb_cont_sequencer.sv - scoreboard bench for cont_sequencer
module tb_cont_sequencer;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   busy_cnt;

  // {phase, sa1, sa2, round, busy, done}
  logic [15:0] exp_q[$];

  cont_sequencer_if #(.WIDTH(4), .RWIDTH(4)) bus ();

  cont_sequencer #(.WIDTH(4), .RWIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int ph, input int s1, input int s2, input int r);
    logic [15:0] e;
    e = {2'(ph), 4'(s1), 4'(s2), 4'(r), (ph == 1 || ph == 2), (ph == 3)};
    exp_q.push_back(e);
  endtask

  // Expected busy/done trace of one full sequence, built from the round structure
  task automatic gen_trace(input int l1, input int l2, input int r);
    if (r == 0) begin
      push(3, 0, 0, 0);
    end else begin
      for (int rr = 0; rr < r; rr++) begin
        for (int i = 0; i <= l1; i++) push(1, i, 0, rr);
        for (int j = 0; j <= l2; j++) push(2, l1, j, rr);
      end
      push(3, l1, l2, r - 1);
    end
  endtask

  always @(negedge clock) begin
    if (reset && (bus.busy || bus.done)) begin
      logic [15:0] act;
      logic [15:0] e;
      act = {bus.phase, bus.sa1, bus.sa2, bus.round, bus.busy, bus.done};
      if (bus.busy) busy_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got ph=%0d sa1=%0d sa2=%0d rnd=%0d busy=%0b done=%0b expected none",
                 act[15:14], act[13:10], act[9:6], act[5:2], act[1], act[0]);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL trace: got ph=%0d sa1=%0d sa2=%0d rnd=%0d busy=%0b done=%0b expected ph=%0d sa1=%0d sa2=%0d rnd=%0d busy=%0b done=%0b",
                   act[15:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
                   e[15:14], e[13:10], e[9:6], e[5:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clock);
      if (bus.done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, int'(seen), 1);
  endtask

  task automatic check_idle(input string name, input int s1, input int s2, input int r);
    @(negedge clock);
    chk({name, "_phase"}, int'(bus.phase), 0);
    chk({name, "_busy"}, int'(bus.busy), 0);
    chk({name, "_sa1"}, int'(bus.sa1), s1);
    chk({name, "_sa2"}, int'(bus.sa2), s2);
    chk({name, "_round"}, int'(bus.round), r);
  endtask

  task automatic run_seq(input string name, input int l1, input int l2, input int r);
    gen_trace(l1, l2, r);
    @(posedge clock); #1;
    bus.lim1 = 4'(l1);
    bus.lim2 = 4'(l2);
    bus.rounds = 4'(r);
    bus.start = 1'b1;
    busy_cnt = 0;
    @(posedge clock); #1;
    bus.start = 1'b0;
    wait_done(name);
    chk({name, "_busy_cycles"}, busy_cnt, r * (l1 + l2 + 2));
    if (r == 0) check_idle(name, 0, 0, 0);
    else check_idle(name, l1, l2, r - 1);
  endtask

  initial begin
    bit hit;
    n_tests = 0;
    n_fail = 0;
    busy_cnt = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.lim1 = 4'd0;
    bus.lim2 = 4'd0;
    bus.rounds = 4'd0;

    repeat (10) @(posedge clock);
    #1;
    chk("reset_phase", int'(bus.phase), 0);
    chk("reset_sa1", int'(bus.sa1), 0);
    chk("reset_sa2", int'(bus.sa2), 0);
    chk("reset_round", int'(bus.round), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    reset = 1'b1;

    run_seq("basic", 3, 2, 2);
    run_seq("zero_lims", 0, 0, 3);
    run_seq("zero_rounds", 0, 0, 0);
    run_seq("max_lims", 15, 15, 1);

    // start held high, lim1 changed mid-run, then relaunch from the held start
    gen_trace(2, 1, 1);
    gen_trace(9, 1, 1);
    @(posedge clock); #1;
    bus.lim1 = 4'd2;
    bus.lim2 = 4'd1;
    bus.rounds = 4'd1;
    bus.start = 1'b1;
    busy_cnt = 0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clock);
      if (bus.phase == 2'd1 && bus.sa1 == 4'd1) hit = 1'b1;
    end
    chk("hold_midrun_seen", int'(hit), 1);
    bus.lim1 = 4'd9;
    wait_done("hold1");
    chk("hold1_busy_cycles", busy_cnt, 5);
    @(negedge clock);
    chk("hold_gap_phase", int'(bus.phase), 0);
    chk("hold_gap_sa1", int'(bus.sa1), 2);
    @(posedge clock); #1;
    bus.start = 1'b0;
    busy_cnt = 0;
    wait_done("hold2");
    chk("hold2_busy_cycles", busy_cnt, 12);
    check_idle("hold2", 9, 1, 0);

    // abort when sa2 reaches 1 in round 0
    repeat (6) push(0, 0, 0, 0);
    repeat (6) void'(exp_q.pop_back());
    for (int i = 0; i <= 3; i++) push(1, i, 0, 0);
    push(2, 3, 0, 0);
    push(2, 3, 1, 0);
    @(posedge clock); #1;
    bus.lim1 = 4'd3;
    bus.lim2 = 4'd2;
    bus.rounds = 4'd2;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clock);
      if (bus.phase == 2'd2 && bus.sa2 == 4'd1) hit = 1'b1;
    end
    chk("abort_point_seen", int'(hit), 1);
    bus.abort = 1'b1;
    @(posedge clock); #1;
    bus.abort = 1'b0;
    chk("abort_phase", int'(bus.phase), 0);
    chk("abort_sa1", int'(bus.sa1), 0);
    chk("abort_sa2", int'(bus.sa2), 0);
    chk("abort_round", int'(bus.round), 0);
    chk("abort_done", int'(bus.done), 0);
    repeat (4) @(posedge clock);

    // asynchronous reset between edges while sa1=2 in RUN1
    for (int i = 0; i <= 2; i++) push(1, i, 0, 0);
    @(posedge clock); #1;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clock);
      if (bus.phase == 2'd1 && bus.sa1 == 4'd2) hit = 1'b1;
    end
    chk("areset_point_seen", int'(hit), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_phase", int'(bus.phase), 0);
    chk("areset_sa1", int'(bus.sa1), 0);
    chk("areset_busy", int'(bus.busy), 0);
    chk("areset_done", int'(bus.done), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    run_seq("after_reset", 1, 1, 1);

    repeat (3) @(posedge clock);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
